// File: rtl/button_run_ctrl.sv
// rtl/button_run_ctrl.sv - debounced push button driving a run-enable toggle with press/long-press strobes
// Optional long-press detection is enabled by defining LONG_PRESS_EN.
module button_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int LONG_CYCLES     = 27000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic o1,
  output logic press_pulse,
  output logic long_pulse,
  output logic btn_state
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          press_arm_q, press_arm_d;
  logic          press_pulse_q, press_pulse_d;
  logic          o1_q, o1_d;
  logic          btn_s;
  logic          enter_held;
  logic          long_arm;

  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
  end

  assign btn_s = ~sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      db_cnt_q <= '0;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
    end
  end

  // The counter only advances below DB_LAST, so it can never wrap.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d  = DB_PRESS;
          db_cnt_d = '0;
        end
      end
      DB_PRESS: begin
        if (!btn_s) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DW'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d  = DB_RELEASE;
          db_cnt_d = '0;
        end
      end
      DB_RELEASE: begin
        if (btn_s) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    enter_held = (state_q == DB_PRESS) && btn_s && (db_cnt_q == DB_LAST);
    btn_state  = (state_q == HELD) || (state_q == DB_RELEASE);
  end

  // Press events pass through an arm stage so the strobe lands a fixed DEBOUNCE_CYCLES+3 after the button edge.
  always_comb begin
    press_arm_d   = enter_held;
    press_pulse_d = press_arm_q;
    o1_d          = long_arm ? 1'b0 : (o1_q ^ press_arm_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      press_arm_q   <= 1'b0;
      press_pulse_q <= 1'b0;
      o1_q          <= 1'b0;
    end else begin
      press_arm_q   <= press_arm_d;
      press_pulse_q <= press_pulse_d;
      o1_q          <= o1_d;
    end
  end

  assign press_pulse = press_pulse_q;
  assign o1          = o1_q;

`ifdef LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          long_arm_q, long_arm_d;
  logic          long_pulse_q, long_pulse_d;

  // Cleared only on a fresh press, so release bounces resume the same hold and it fires once.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (enter_held) begin
      hold_cnt_d = '0;
    end else if ((state_q == HELD) && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
    end
    long_arm_d   = (state_q == HELD) && (hold_cnt_q == HOLD_LAST);
    long_pulse_d = long_arm_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q   <= '0;
      long_arm_q   <= 1'b0;
      long_pulse_q <= 1'b0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      long_arm_q   <= long_arm_d;
      long_pulse_q <= long_pulse_d;
    end
  end

  assign long_arm   = long_arm_q;
  assign long_pulse = long_pulse_q;
`else
  assign long_arm   = 1'b0;
  assign long_pulse = 1'b0;
`endif

endmodule
